debug_display_ctrl: RTL
=======================

// Module: debug_display_ctrl
// PURPOSE
//  Parametrised multi-channel debug display for the CPU board: time-multiplexes DIGITS hex
//  digits onto a common seven-segment bank, selects one of CHANNELS debug words, steps the
//  channel with a debounced push-button, and can freeze the shown value. Replaces the
//  fixed 4-digit path (separate divided clock + debouncer); everything runs on CLK via enables.
// PARAMETERS
//  DIGITS     4      number of hex digits / anodes (1..8)
//  CHANNELS   4      number of debug words on data_in (1..16)
//  SCAN_DIV   131072 CLK cycles per digit slot (>=2)
//  DB_CYCLES  1000000 cycles button must be stable before accepted (>=2)
//  BLANK_LZ   0      1 = blank leading zero digits (digit 0 always shown)
// PORTS
//  CLK       in   1                     system clock, all logic on posedge
//  clr       in   1                     reset, asynchronous, active-low
//  button    in   1                     raw channel-step button, asynchronous, bouncy
//  freeze    in   1                     1 = hold currently captured word
//  data_in   in   CHANNELS*DIGITS*4     channel c = data_in[c*DIGITS*4 +: DIGITS*4]
//  pos_ctrl  out  DIGITS                anode enables, active-low, bit0 = rightmost digit
//  num_ctrl  out  8                     {dp,g,f,e,d,c,b,a}, active-low
//  chan_sel  out  clog2(CHANNELS) (min 1)  channel currently shown
// BEHAVIOUR
//  Reset (clr=0, async): pos_ctrl=all 1, num_ctrl=8'hFF, chan_sel=0, digit index=0,
//   scan counter=0, debounce counter=0, debounced level=0, snapshot=0.
//  Button: 2-FF synchroniser -> debouncer; sync level differing from debounced level for
//   DB_CYCLES consecutive cycles updates the level (counter clears on any agreement).
//   Debounced 0->1 gives one-cycle step pulse; release produces nothing.
//  Channel: step pulse increments chan_sel; CHANNELS-1 wraps to 0. CHANNELS=1: stays 0.
//  Snapshot: each cycle freeze=0, snapshot <= selected channel word (chan_sel after any
//   same-cycle step takes effect next cycle). freeze=1 holds snapshot; chan_sel still steps
//   but display keeps frozen word until freeze=0.
//  Scan: counter counts 0..SCAN_DIV-1; terminal count = tick, counter wraps to 0. On tick
//   digit index advances (DIGITS-1 wraps to 0) and outputs register new digit. Outputs
//   blank (all 1) until first tick after reset; thereafter exactly one pos_ctrl bit low.
//   Output latency: pos_ctrl/num_ctrl registered, change 1 cycle after tick.
//  Decode nibble n of snapshot for digit n: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
//   8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (num_ctrl, dp bit=1).
//  Decimal point: dp low (bit7=0) on digit whose index == chan_sel (channel indicator);
//   none lit when chan_sel >= DIGITS.
//  BLANK_LZ=1: digit n>0 with it and all higher nibbles zero -> segments 7'h7F, dp rule
//   still applies; anode still driven.
//  Simultaneous step pulse and tick: both take effect; no event lost.
//  Reset mid-scan/mid-debounce: immediate return to reset values; partially counted
//   press discarded.
// TESTING
//  T1 clr=0 pulse mid-run -> pos_ctrl=4'hF, num_ctrl=8'hFF, chan_sel=0 immediately (async).
//  T2 SCAN_DIV=4, ch0=16'h1234 -> pos_ctrl E,D,B,7,E... every 4 cycles; num_ctrl 99(dp 19),B0,A4,F9.
//  T3 DB_CYCLES=8: button glitch of 7 cycles -> no step; held 10 cycles -> chan_sel 0->1 once.
//  T4 four clean presses, CHANNELS=4 -> chan_sel 1,2,3,0; dp moves digit1,2,3,0.
//  T5 freeze=1, then change data_in and step channel -> num_ctrl pattern unchanged; freeze=0 -> new word next scan.
//  T6 BLANK_LZ=1, word 16'h0050 -> digits3 blank (7F), 1 shows 92, 0 shows C0.

Source files
------------

// File: rtl/debug_display_ctrl.sv
// Multi-channel seven-segment debug display: selects one of CHANNELS debug words, steps the
// channel with a debounced button, optionally freezes the word, and scans DIGITS hex digits.
module debug_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int CHANNELS  = 4,
  parameter int SCAN_DIV  = 131072,
  parameter int DB_CYCLES = 1000000,
  parameter int BLANK_LZ  = 0,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         CLK,
  input  logic                         clr,
  input  logic                         button,
  input  logic                         freeze,
  input  logic [CHANNELS*DIGITS*4-1:0] data_in,
  output logic [DIGITS-1:0]            pos_ctrl,
  output logic [7:0]                   num_ctrl,
  output logic [CHAN_W-1:0]            chan_sel
);

  localparam int WORD_W = DIGITS * 4;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DB_CYCLES);

  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST  = CHAN_W'(CHANNELS - 1);
  localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(DIGITS - 1);

  logic              btn_meta, btn_sync, db_level, step_pulse;
  logic [DB_W-1:0]   db_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DIG_W-1:0]  digit_idx;
  logic [WORD_W-1:0] snapshot, word_sel;
  logic [3:0]        nibble;
  logic              upper_zero, dp_on, blank, tick;
  logic [6:0]        seg;

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    word_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (chan_sel == CHAN_W'(c)) word_sel = data_in[c*WORD_W +: WORD_W];
  end

  always_comb begin
    nibble     = '0;
    upper_zero = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (digit_idx == DIG_W'(d)) begin
        nibble     = snapshot[d*4 +: 4];
        upper_zero = ((snapshot >> (4 * d)) == '0);
      end
  end

  assign tick  = (scan_cnt == SCAN_LAST);
  assign dp_on = (int'(chan_sel) == int'(digit_idx));
  assign blank = (BLANK_LZ != 0) && (digit_idx != '0) && upper_zero;
  assign seg   = blank ? 7'h7F : hex_to_seg(nibble);

  // Synchroniser and debouncer; the step pulse fires only on an accepted press.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      db_level   <= 1'b0;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      btn_meta   <= button;
      btn_sync   <= btn_meta;
      step_pulse <= 1'b0;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        db_level   <= btn_sync;
        step_pulse <= btn_sync;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      chan_sel <= '0;
      snapshot <= '0;
    end else begin
      if (step_pulse) chan_sel <= (chan_sel == CHAN_LAST) ? '0 : chan_sel + CHAN_W'(1);
      if (!freeze) snapshot <= word_sel;
    end
  end

  // On each tick the current digit is registered onto the outputs, then the index advances.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      pos_ctrl  <= '1;
      num_ctrl  <= 8'hFF;
    end else if (tick) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DIG_W'(1);
      pos_ctrl  <= ~(DIGITS'(1) << digit_idx);
      num_ctrl  <= {~dp_on, seg};
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule
